// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS definitions: widths, dmem size codes, dmem FSM states
package mips_defs;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    DMEM_SIZE_B   = 2'b00,
    DMEM_SIZE_H   = 2'b01,
    DMEM_SIZE_W   = 2'b10,
    DMEM_SIZE_RSV = 2'b11
  } dmem_size_e;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_BUSY = 2'b01,
    DMEM_RESP = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_mux.sv
// rtl/dmem_lane_mux.sv - byte-lane merge for stores and lane select/extend for loads
module dmem_lane_mux
  import mips_defs::*;
(
  input  logic [REG_DATA_WIDTH-1:0] old_word,
  input  logic [REG_DATA_WIDTH-1:0] wdata,
  input  dmem_size_e                size,
  input  logic [1:0]                offset,
  input  logic                      is_signed,
  output logic [REG_DATA_WIDTH-1:0] store_word,
  output logic [REG_DATA_WIDTH-1:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    store_word = old_word;
    case (size)
      DMEM_SIZE_B: store_word[{offset, 3'b000} +: 8]   = wdata[7:0];
      DMEM_SIZE_H: store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      DMEM_SIZE_W: store_word = wdata;
      default:     store_word = old_word;
    endcase
  end

  always_comb begin
    lane_b    = old_word[{offset, 3'b000} +: 8];
    lane_h    = old_word[{offset[1], 4'b0000} +: 16];
    load_data = '0;
    case (size)
      DMEM_SIZE_B: load_data = {{24{is_signed & lane_b[7]}}, lane_b};
      DMEM_SIZE_H: load_data = {{16{is_signed & lane_h[15]}}, lane_h};
      DMEM_SIZE_W: load_data = old_word;
      default:     load_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder, req/resp handshakes; DMEM_WAIT_EN adds a wait state
module dmem_responder
  import mips_defs::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [31:0]               req_addr,
  input  logic [REG_DATA_WIDTH-1:0] req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [REG_DATA_WIDTH-1:0] resp_rdata,
  output logic                      resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [REG_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  dmem_state_e               state, state_d;
  logic                      ready_q;
  logic [REG_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      accept, req_err, do_access, do_write;

  logic                      acc_we, acc_signed;
  dmem_size_e                acc_size;
  logic [IDX_W-1:0]          acc_idx;
  logic [1:0]                acc_off;
  logic [REG_DATA_WIDTH-1:0] acc_wdata, old_word, store_word, load_data;

  assign accept = req_valid && ready_q;

  assign req_err = (dmem_size_e'(req_size) == DMEM_SIZE_RSV)
                || (dmem_size_e'(req_size) == DMEM_SIZE_H && req_addr[0])
                || (dmem_size_e'(req_size) == DMEM_SIZE_W && req_addr[1:0] != 2'b00)
                || ((req_addr >> (IDX_W + 2)) != 32'd0);

`ifdef DMEM_WAIT_EN
  logic [3:0]                wait_cnt, wait_cnt_d;
  logic                      cap_we, cap_signed;
  dmem_size_e                cap_size;
  logic [IDX_W-1:0]          cap_idx;
  logic [1:0]                cap_off;
  logic [REG_DATA_WIDTH-1:0] cap_wdata;

  // Request is held here so the delayed access does not depend on req_* staying put.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we     <= req_we;
      cap_signed <= req_signed;
      cap_size   <= dmem_size_e'(req_size);
      cap_idx    <= req_addr[IDX_W+1:2];
      cap_off    <= req_addr[1:0];
      cap_wdata  <= req_wdata;
    end
  end

  always_comb begin
    if (state == DMEM_BUSY) begin
      acc_we     = cap_we;
      acc_signed = cap_signed;
      acc_size   = cap_size;
      acc_idx    = cap_idx;
      acc_off    = cap_off;
      acc_wdata  = cap_wdata;
    end else begin
      acc_we     = req_we;
      acc_signed = req_signed;
      acc_size   = dmem_size_e'(req_size);
      acc_idx    = req_addr[IDX_W+1:2];
      acc_off    = req_addr[1:0];
      acc_wdata  = req_wdata;
    end
  end
`else
  assign acc_we     = req_we;
  assign acc_signed = req_signed;
  assign acc_size   = dmem_size_e'(req_size);
  assign acc_idx    = req_addr[IDX_W+1:2];
  assign acc_off    = req_addr[1:0];
  assign acc_wdata  = req_wdata;
`endif

  assign old_word = mem[acc_idx];

  dmem_lane_mux u_lane_mux (
    .old_word   (old_word),
    .wdata      (acc_wdata),
    .size       (acc_size),
    .offset     (acc_off),
    .is_signed  (acc_signed),
    .store_word (store_word),
    .load_data  (load_data)
  );

  always_comb begin
    state_d   = state;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;
`ifdef DMEM_WAIT_EN
    wait_cnt_d = wait_cnt;
`endif
    case (state)
      DMEM_IDLE: begin
        if (accept) begin
          if (req_err) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = DMEM_RESP;
`ifdef DMEM_WAIT_EN
          end else if (WAIT_CYCLES != 0) begin
            wait_cnt_d = 4'(WAIT_CYCLES);
            state_d    = DMEM_BUSY;
`endif
          end else begin
            do_access = 1'b1;
            state_d   = DMEM_RESP;
          end
        end
      end
`ifdef DMEM_WAIT_EN
      DMEM_BUSY: begin
        wait_cnt_d = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          do_access = 1'b1;
          state_d   = DMEM_RESP;
        end
      end
`endif
      DMEM_RESP: begin
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = DMEM_IDLE;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase
    if (do_access) begin
      rdata_d = acc_we ? '0 : load_data;
      err_d   = 1'b0;
    end
  end

  // Gated by rst_n so a store pending in BUSY is dropped by a reset.
  assign do_write = do_access && acc_we && rst_n;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[acc_idx] <= store_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= DMEM_IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_WAIT_EN
      wait_cnt <= 4'd0;
`endif
    end else begin
      state   <= state_d;
      ready_q <= (state_d == DMEM_IDLE);
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DMEM_WAIT_EN
      wait_cnt <= wait_cnt_d;
`endif
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = (state == DMEM_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS pipeline: the far end of the load/store requests issued by the memory stage. Accepts one request at a time over a valid/ready handshake, performs byte/half/word reads and writes on an internal word-organised array, and returns the load data or an error over a second valid/ready handshake. Sits between the memory stage and the writeback path; the memory stage stalls until the response is taken.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words in the array; must be a power of two.
- WAIT_CYCLES, 2: extra access latency in cycles; used only when DMEM_WAIT_EN is defined. Legal range 0–15.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is reserved and treated as an error
- req_signed  in  1  load sign-extension (byte/half only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or reserved-size request

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready = 1. On req_valid && req_ready, capture all req_* fields.
  - Error if any of: half with addr[0] ≠ 0; word with addr[1:0] ≠ 0; size = 11; addr[31:log2(DEPTH_WORDS)+2] ≠ 0.
  - On error, go to RESP with resp_err = 1. The array is not touched.
  - Otherwise, with wait enabled and WAIT_CYCLES > 0, load wait counter = WAIT_CYCLES and go to BUSY.
  - Otherwise perform the access and go to RESP.
- BUSY: decrement the counter each cycle. In the cycle the counter is 1, perform the access and go to RESP.
- Access:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Store: write the byte lanes selected by size and addr[1:0]; other lanes are unchanged.
  - Load: select lanes, then zero- or sign-extend according to req_signed. Word loads ignore req_signed.
- RESP: resp_valid = 1. resp_rdata and resp_err are held stable until resp_ready. On handshake, go to IDLE.
- resp_rdata = 0 whenever resp_valid = 0.
- Reset mid-operation:
  - State goes to IDLE and all outputs return to their reset values.
  - A store already performed stays performed. A store still pending in BUSY is dropped.
  - Array contents are not reset.

## Timing
- Reset values: req_ready = 0 while rst_n = 0 and 1 from the first cycle after release. resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Request accepted at edge N:
  - Without wait: resp_valid is high after edge N+1.
  - With wait: resp_valid is high after edge N+1+WAIT_CYCLES.
  - Error requests always respond after edge N+1.
- req_ready is low from the cycle after acceptance until the cycle after the response handshake. Peak throughput is one request per 2+WAIT_CYCLES cycles.
- The store write lands at the edge that enters RESP. A load issued afterwards sees the new data.
- If resp_ready is already high when resp_valid rises, the handshake completes in that cycle. There is no combinational path from req_* to resp_*.

## Configuration
- DMEM_WAIT_EN defined: the BUSY state and the 4-bit wait counter are present, and latency follows WAIT_CYCLES.
- DMEM_WAIT_EN undefined: no BUSY state and no counter. Every request responds one cycle after acceptance, and WAIT_CYCLES is ignored.

## Structure
- Shared package (mips_defs):
  - size encodings DMEM_SIZE_B/H/W/RSV
  - FSM state encoding
  - REG_DATA_WIDTH / REG_ADDR_WIDTH reuse
- Sub-module dmem_lane_mux (combinational):
  - store: builds the merged word from the old word, wdata, size and offset
  - load: builds the extended result from the word, size, offset and signed
- FSM, counter, array and handshake logic stay in dmem_responder.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x10, then load word at 0x10. Expect resp_rdata = 0xDEADBEEF and resp_err = 0. Latency is 1+WAIT_CYCLES after acceptance.
- Byte lanes and sign extension:
  - Store byte 0x80 at 0x21 over a word of 0.
  - Signed byte load at 0x21 gives 0xFFFFFF80; unsigned gives 0x00000080.
  - Word load at 0x20 gives 0x00008000.
- Half store and load: store half 0x8001 at 0x32, then signed half load at 0x32. Expect 0xFFFF8001.
- Errors:
  - Half access at 0x33: resp_err = 1, resp_rdata = 0, memory unchanged.
  - Word access at DEPTH_WORDS*4: resp_err = 1.
  - Both respond one cycle after acceptance, even with wait enabled.
- Backpressure: hold resp_ready = 0 for 5 cycles during a load response. resp_valid, resp_rdata and resp_err stay stable, req_ready stays 0, and a req_valid pulse in that window is not accepted.
- Reset mid-BUSY (DMEM_WAIT_EN, WAIT_CYCLES = 3):
  - Assert rst_n = 0 one cycle after a store to 0x40 is accepted. Outputs go to 0 on the next edge.
  - After release, a load at 0x40 returns the old value.
